// File: rtl/ja_input_port_pkg.sv
// ja_input_port_pkg: register offsets and pin count shared by the JA input peripheral
package ja_input_port_pkg;
    localparam int JA_WIDTH = 8;
    localparam logic [1:0] IO_LEVEL = 2'd0;
    localparam logic [1:0] IO_RISE  = 2'd1;
    localparam logic [1:0] IO_FALL  = 2'd2;
    localparam logic [1:0] IO_MASK  = 2'd3;
endpackage

// File: rtl/ja_input_port_pin_debouncer.sv
// pin_debouncer: 2-flop synchroniser and stability counter for one raw pin
module pin_debouncer #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sync1, s, accept;
    logic [CNT_W-1:0] cnt;
    // rise/fall are single-cycle strobes aligned with the edge that updates level
    assign accept = (s != level) && (cnt == CNT_W'(DEBOUNCE - 1));
    assign rise = accept && s;
    assign fall = accept && !s;
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            if (s == level) cnt <= '0;
            else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else if (cnt != '1) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ja_input_port.sv
// ja_input_port: debounced JA pin inputs with sticky edge flags, irq mask and dmem read/write window
module ja_input_port
    import ja_input_port_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = 12'hF00,
    parameter int          DEBOUNCE  = 4,
    parameter int          CNT_W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [JA_WIDTH-1:0] pins,
    input  logic [11:0]         addr,
    input  logic                wEn,
    input  logic [31:0]         dataIn,
    output logic [31:0]         dataOut,
    output logic                hit,
    output logic                irq
);
    logic [JA_WIDTH-1:0] level, rise_set, fall_set, rise, fall, mask, rd, wdata;
    logic [11:0] off;
    logic in_win, we, unused_bits;
    assign off = addr - BASE_ADDR;
    assign in_win = off[11:2] == '0;
    assign we = wEn && in_win;
    assign wdata = dataIn[JA_WIDTH-1:0];
    assign unused_bits = ^dataIn[31:JA_WIDTH];
    for (genvar i = 0; i < JA_WIDTH; i++) begin : g_pin
        pin_debouncer #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_pin (
            .clock(clock),
            .reset(reset),
            .raw  (pins[i]),
            .level(level[i]),
            .rise (rise_set[i]),
            .fall (fall_set[i])
        );
    end
    always_comb
        rd = off[1:0] == IO_LEVEL ? level :
             off[1:0] == IO_RISE  ? rise  :
             off[1:0] == IO_FALL  ? fall  : mask;
    // new edges are ORed in after the W1C so a coincident set survives the clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            rise    <= '0;
            fall    <= '0;
            mask    <= '0;
            dataOut <= '0;
            hit     <= 1'b0;
            irq     <= 1'b0;
        end else begin
            rise    <= (rise & ~(we && off[1:0] == IO_RISE ? wdata : '0)) | rise_set;
            fall    <= (fall & ~(we && off[1:0] == IO_FALL ? wdata : '0)) | fall_set;
            mask    <= we && off[1:0] == IO_MASK ? wdata : mask;
            dataOut <= in_win ? 32'(rd) : '0;
            hit     <= in_win;
            irq     <= |((rise | fall) & mask);
        end
    end
endmodule
